// File: rtl/breathe_multi.sv
// breathe_multi: multi-channel LED breathing / PWM generator.
// A shared prescaler paces a triangle-wave brightness level; a shared
// free-running PWM counter turns that level into per-channel LED drive.
// Each channel picks off / on / breathe / blink and may run anti-phase.
// Optional build macro: BREATHE_MULTI_GAMMA_EN squares the breathe-mode
// duty (registered), adding one clock of breathe-mode latency.

// Per-channel LED drive: mode decode, anti-phase, PWM compare.
module breathe_multi_ch #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic                i_phase_inv,
  input  logic [PWM_BITS-1:0] i_level,
  input  logic                i_inhale,
  input  logic [PWM_BITS-1:0] i_pwm,
  output logic                o_led
);
  logic [PWM_BITS-1:0] w_duty;
  logic [PWM_BITS-1:0] w_duty_pwm;
  logic                w_led;
  logic                r_led;

  assign w_duty = i_phase_inv ? ~i_level : i_level;

`ifdef BREATHE_MULTI_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_prod;
  logic [PWM_BITS-1:0]   r_duty_g;

  assign w_prod = {{PWM_BITS{1'b0}}, w_duty} * {{PWM_BITS{1'b0}}, w_duty};

  // Gamma-corrected duty, registered to keep the multiplier off the LED path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_duty_g <= '0;
    else        r_duty_g <= PWM_BITS'(w_prod >> PWM_BITS);
  end

  assign w_duty_pwm = r_duty_g;
`else
  assign w_duty_pwm = w_duty;
`endif

  // Mode decode; blink follows the breath direction, flipped for anti-phase.
  always_comb begin
    w_led = 1'b0;
    case (i_mode)
      2'b00:   w_led = 1'b0;
      2'b01:   w_led = 1'b1;
      2'b10:   w_led = (i_pwm < w_duty_pwm);
      default: w_led = i_inhale ^ i_phase_inv;
    endcase
  end

  // Registered LED drive, blanked whenever the block is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_led <= 1'b0;
    else        r_led <= i_enable ? w_led : 1'b0;
  end

  assign o_led = r_led;
endmodule

// Top: shared prescaler, PWM counter, level sequencer and channel array.
module breathe_multi #(
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8,
  parameter int DIV_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_BITS-1:0]   step_div,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   phase_inv,
  output logic [CHANNELS-1:0]   led,
  output logic [PWM_BITS-1:0]   level,
  output logic                  inhale,
  output logic                  step_tick
);
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  typedef enum logic {ST_EXHALE = 1'b0, ST_INHALE = 1'b1} state_t;

  logic [DIV_BITS-1:0] r_presc;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_level;
  state_t              r_state;
  logic                w_tick;
  logic [PWM_BITS-1:0] w_level_nxt;
  state_t              w_state_nxt;

  // >= rather than == so lowering step_div mid-count still ticks promptly.
  assign w_tick = enable && (r_presc >= step_div);

  // Prescaler and step pulse; both freeze (pulse low) while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_tick)      r_presc <= '0;
      else if (enable) r_presc <= r_presc + DIV_BITS'(1);
    end
  end

  // Free-running PWM counter, independent of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pwm <= '0;
    else        r_pwm <= r_pwm + PWM_BITS'(1);
  end

  // Level/direction state register, advanced only on a step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
      r_state <= ST_INHALE;
    end else if (w_tick) begin
      r_level <= w_level_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Triangle turning rules: each endpoint is held for exactly one step.
  always_comb begin
    w_level_nxt = r_level;
    w_state_nxt = r_state;
    case (r_state)
      ST_INHALE: begin
        if (r_level == MAX) begin
          w_level_nxt = MAX - PWM_BITS'(1);
          w_state_nxt = ST_EXHALE;
        end else begin
          w_level_nxt = r_level + PWM_BITS'(1);
        end
      end
      default: begin
        if (r_level == '0) begin
          w_level_nxt = PWM_BITS'(1);
          w_state_nxt = ST_INHALE;
        end else begin
          w_level_nxt = r_level - PWM_BITS'(1);
        end
      end
    endcase
  end

  assign level     = r_level;
  assign inhale    = (r_state == ST_INHALE);
  assign step_tick = r_tick;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    breathe_multi_ch #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_enable   (enable),
      .i_mode     (mode[2*i +: 2]),
      .i_phase_inv(phase_inv[i]),
      .i_level    (r_level),
      .i_inhale   (inhale),
      .i_pwm      (r_pwm),
      .o_led      (led[i])
    );
  end
endmodule

// File: tb/tb_breathe_multi.sv
// Bench for breathe_multi (PWM_BITS=4). Step events are scored by a
// monitor that pops expected level/inhale pairs on each step_tick;
// timing, duty and reset behaviour are checked directly.
module tb_breathe_multi;
  localparam int CH = 4;
  localparam int PB = 4;
  localparam int DB = 24;

`ifdef BREATHE_MULTI_GAMMA_EN
  localparam int D0 = 0, D15 = 14, D5 = 1, D10 = 6;
`else
  localparam int D0 = 0, D15 = 15, D5 = 5, D10 = 10;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [DB-1:0] step_div = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0] phase_inv = '0;
  logic [CH-1:0] led;
  logic [PB-1:0] level;
  logic          inhale;
  logic          step_tick;

  breathe_multi #(.CHANNELS(CH), .PWM_BITS(PB), .DIV_BITS(DB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step_div(step_div),
    .mode(mode), .phase_inv(phase_inv), .led(led), .level(level),
    .inhale(inhale), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PB-1:0] lvl;
    logic          inh;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push(input int lv, input bit inh);
    exp_t e;
    e.lvl = lv[PB-1:0];
    e.inh = inh;
    q.push_back(e);
  endtask

  // Clocks from the call point until step_tick is seen (bounded).
  task automatic wait_tick(input int exp, input string nm);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!step_tick && n < 200);
    chk(nm, n, exp);
  endtask

  // LED high-counts over one full 16-clock PWM period.
  task automatic count16(output int c0, output int c1, output int c3);
    c0 = 0; c1 = 0; c3 = 0;
    repeat (16) begin
      @(negedge clk); #1;
      c0 += int'(led[0]);
      c1 += int'(led[1]);
      c3 += int'(led[3]);
    end
  endtask

  // Scoreboard monitor: every step must match the next expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en && step_tick) begin
      if (q.size() == 0) chk("unexpected step_tick", 1, 0);
      else begin
        e = q.pop_front();
        chk("step level", int'(level), int'(e.lvl));
        chk("step inhale", int'(inhale), int'(e.inh));
      end
    end
  end

  initial begin
    int n, bad, nt, c0, c1, c3;
    bit prev_inh;
    // ch0 off, ch1 on, ch2 blink, ch3 breathe
    mode = 8'b10_11_01_00;
    enable = 1'b1;
    step_div = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset led", int'(led), 0);
    chk("reset level", int'(level), 0);
    chk("reset step_tick", int'(step_tick), 0);
    chk("reset inhale", int'(inhale), 1);

    // Full breath with a tick every clock: 1..15, 14..0, then 1.
    for (int k = 1; k <= 31; k++) begin
      if (k <= 15)      push(k, 1'b1);
      else if (k <= 30) push(30 - k, 1'b0);
      else              push(1, 1'b1);
    end
    mon_en = 1'b1;
    prev_inh = 1'b1;
    bad = 0;
    n = 0;
    reset = 1'b1;
    do begin
      @(negedge clk); #1;
      n++;
      if (led[2] !== prev_inh) bad++;
      prev_inh = inhale;
    end while (q.size() != 0 && n < 100);
    chk("breath clocks", n, 31);
    chk("blink tracks inhale", bad, 0);

    // step_div=9: one tick per 10 clocks; then lower to 3 at prescaler 7.
    for (int lv = 2; lv <= 7; lv++) push(lv, 1'b1);
    step_div = 24'd9;
    wait_tick(10, "div9 interval a");
    wait_tick(10, "div9 interval b");
    wait_tick(10, "div9 interval c");
    repeat (7) begin @(negedge clk); #1; end
    step_div = 24'd3;
    wait_tick(1, "div lowered tick");
    wait_tick(4, "div3 interval a");
    wait_tick(4, "div3 interval b");

    // Disable at level 7 with prescaler held at 2.
    repeat (2) begin @(negedge clk); #1; end
    enable = 1'b0;
    @(negedge clk); #1;
    chk("disable led", int'(led), 0);
    nt = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (step_tick) nt++;
    end
    chk("disabled ticks", nt, 0);
    chk("disabled level", int'(level), 7);
    chk("disabled inhale", int'(inhale), 1);
    push(8, 1'b1);
    enable = 1'b1;
    wait_tick(2, "resume tick");

    // Async reset mid-count while stepping every clock.
    mon_en = 1'b0;
    step_div = '0;
    repeat (3) begin @(negedge clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    chk("async led", int'(led), 0);
    chk("async level", int'(level), 0);
    chk("async step_tick", int'(step_tick), 0);
    chk("async inhale", int'(inhale), 1);

    // Level 0 held: duty boundaries 0 and MAX.
    step_div = '1;
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    count16(c0, c1, c3);
    chk("off mode count", c0, 0);
    chk("on mode count", c1, 16);
    chk("duty level0", c3, D0);
    phase_inv[3] = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    count16(c0, c1, c3);
    chk("duty inv level0", c3, D15);
    phase_inv = '0;

    // Step up to level 5 and hold it there.
    for (int lv = 1; lv <= 5; lv++) push(lv, 1'b1);
    mon_en = 1'b1;
    step_div = '0;
    repeat (5) begin @(negedge clk); #1; end
    step_div = '1;
    chk("held level", int'(level), 5);
    chk("queue drained", q.size(), 0);
    repeat (3) begin @(negedge clk); #1; end
    count16(c0, c1, c3);
    chk("duty level5", c3, D5);
    phase_inv = 4'b1100;
    @(negedge clk); #1;
    chk("blink anti-phase", int'(led[2]), 0);
    repeat (2) begin @(negedge clk); #1; end
    count16(c0, c1, c3);
    chk("duty inv level5", c3, D10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
